// File: rtl/spike_encoder.sv
// spike_encoder: turns a timestep's stream of neuron results into address-event
// packets {core_id, neuron_idx}. Spiking neurons are queued in a first-word
// fall-through FIFO; spikes that find the FIFO full are dropped and counted.
module spike_encoder #(
    parameter int NUM_NEURONS   = 256,
    parameter int CORE_ID_WIDTH = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic [CORE_ID_WIDTH-1:0]                      core_id_i,
    input  logic                                          tick_i,
    input  logic                                          neuron_valid_i,
    input  logic [$clog2(NUM_NEURONS)-1:0]                neuron_idx_i,
    input  logic                                          spike_i,
    output logic [CORE_ID_WIDTH+$clog2(NUM_NEURONS)-1:0]  packet_o,
    output logic                                          packet_valid_o,
    input  logic                                          packet_ready_i,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          overflow_o,
    output logic [CNT_WIDTH-1:0]                          drop_count_o
);

    localparam int IDX_W  = $clog2(NUM_NEURONS);
    localparam int PKT_W  = CORE_ID_WIDTH + IDX_W;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [PTR_W-1:0] ONE_ENTRY = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                   state_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     overflow_q;
    logic [CNT_WIDTH-1:0]     drop_q;
    logic [CORE_ID_WIDTH-1:0] core_id_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         occupancy;
    logic [PKT_W-1:0]         mem_q [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic drop;
    logic last_accept;
    logic drain_done;

    // Saturating increment for the drop counter: sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // FIFO status, handshake decode and next pointers.
    always_comb begin
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                      (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
        occupancy   = wr_ptr_q - rd_ptr_q;
        pop         = !fifo_empty && packet_ready_i;
        push_req    = (state_q == COLLECT) && neuron_valid_i && spike_i;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok     = push_req && (!fifo_full || pop);
        drop        = push_req && !push_ok;
        last_accept = (state_q == COLLECT) && neuron_valid_i && (neuron_idx_i == LAST_IDX);
        // Leave DRAIN as soon as the queue is empty or its last entry leaves now.
        drain_done  = fifo_empty || ((occupancy == ONE_ENTRY) && pop);
        wr_ptr_d    = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_ok};
        rd_ptr_d    = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    end

    // Packet storage; only pointers gate visibility, so the array needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {core_id_q, neuron_idx_i};
        end
    end

    // FIFO pointers; reset empties the queue and hides any stale entries.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Timestep FSM with registered busy/done and per-timestep drop statistics.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            core_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_i) begin
                        state_q    <= COLLECT;
                        busy_q     <= 1'b1;
                        core_id_q  <= core_id_i;
                        overflow_q <= 1'b0;
                        drop_q     <= '0;
                    end
                end
                COLLECT: begin
                    if (drop) begin
                        overflow_q <= 1'b1;
                        drop_q     <= sat_inc(drop_q);
                    end
                    if (last_accept) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Head of queue is presented directly; zero whenever nothing is queued.
    assign packet_valid_o = !fifo_empty;
    assign packet_o       = fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign overflow_o     = overflow_q;
    assign drop_count_o   = drop_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder at default parameters (256 neurons,
// 1-bit core id, 16-entry FIFO, 8-bit drop counter).
module tb_spike_encoder;

    logic       clk_i;
    logic       rst_n_i;
    logic [0:0] core_id_i;
    logic       tick_i;
    logic       neuron_valid_i;
    logic [7:0] neuron_idx_i;
    logic       spike_i;
    logic [8:0] packet_o;
    logic       packet_valid_o;
    logic       packet_ready_i;
    logic       busy_o;
    logic       done_o;
    logic       overflow_o;
    logic [7:0] drop_count_o;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [8:0] rx [$];

    spike_encoder #(
        .NUM_NEURONS   (256),
        .CORE_ID_WIDTH (1),
        .FIFO_DEPTH    (16),
        .CNT_WIDTH     (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .core_id_i      (core_id_i),
        .tick_i         (tick_i),
        .neuron_valid_i (neuron_valid_i),
        .neuron_idx_i   (neuron_idx_i),
        .spike_i        (spike_i),
        .packet_o       (packet_o),
        .packet_valid_o (packet_valid_o),
        .packet_ready_i (packet_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o),
        .drop_count_o   (drop_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Record every handshake and done pulse, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_n_i && packet_valid_o && packet_ready_i) rx.push_back(packet_o);
        if (rst_n_i && done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_tick(input logic c);
        @(posedge clk_i); #1;
        tick_i = 1'b1;
        core_id_i = c;
        @(posedge clk_i); #1;
        tick_i = 1'b0;
    endtask

    // Present indices 0..n-1 one per cycle with per-index spike and ready.
    task automatic collect(input logic [255:0] spk, input logic [255:0] rdy, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            neuron_valid_i = 1'b1;
            neuron_idx_i   = 8'(i);
            spike_i        = spk[i];
            packet_ready_i = rdy[i];
        end
        @(posedge clk_i); #1;
        neuron_valid_i = 1'b0;
        spike_i        = 1'b0;
    endtask

    // Wait (bounded) for done_o, then confirm a single pulse and busy falling.
    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk_i);
            if (done_o) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk_i);
        chk({tag, "_done_low"}, 32'(done_o), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy_o), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic chk_rx(input string tag, input logic [8:0] exp [$]);
        chk({tag, "_count"}, 32'(rx.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx.size()) chk($sformatf("%s_pkt%0d", tag, i), 32'(rx[i]), 32'(exp[i]));
        end
    endtask

    logic [255:0] spk;
    logic [255:0] rdy;
    logic [8:0]   exp_q [$];

    initial begin
        rst_n_i = 1'b0;
        core_id_i = 1'b0;
        tick_i = 1'b0;
        neuron_valid_i = 1'b0;
        neuron_idx_i = 8'd0;
        spike_i = 1'b0;
        packet_ready_i = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 32'(packet_valid_o), 32'd0);
        chk("rst_pkt", 32'(packet_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_drop", 32'(drop_count_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Basic timestep: spikes at 3, 100, 255, always ready
        rx.delete(); done_cnt = 0;
        spk = '0; spk[3] = 1'b1; spk[100] = 1'b1; spk[255] = 1'b1;
        rdy = '1;
        do_tick(1'b1);
        @(negedge clk_i);
        chk("basic_busy", 32'(busy_o), 32'd1);
        collect(spk, rdy, 256);
        wait_done("basic");
        exp_q = '{9'h103, 9'h164, 9'h1FF};
        chk_rx("basic", exp_q);

        // Backpressure: 5 spikes held behind ready=0
        rx.delete(); done_cnt = 0;
        spk = '0; spk[10] = 1'b1; spk[20] = 1'b1; spk[30] = 1'b1; spk[40] = 1'b1; spk[50] = 1'b1;
        rdy = '0;
        do_tick(1'b0);
        collect(spk, rdy, 256);
        @(negedge clk_i);
        chk("bp_valid", 32'(packet_valid_o), 32'd1);
        chk("bp_head", 32'(packet_o), 32'h00A);
        repeat (3) @(negedge clk_i);
        chk("bp_hold", 32'(packet_o), 32'h00A);
        chk("bp_busy", 32'(busy_o), 32'd1);
        chk("bp_nodone", 32'(done_cnt), 32'd0);
        packet_ready_i = 1'b1;
        wait_done("bp");
        exp_q = '{9'h00A, 9'h014, 9'h01E, 9'h028, 9'h032};
        chk_rx("bp", exp_q);

        // Overflow: 20 spikes into a 16-entry FIFO with no consumer
        rx.delete(); done_cnt = 0;
        packet_ready_i = 1'b0;
        spk = '0;
        for (int i = 0; i < 20; i++) spk[i] = 1'b1;
        rdy = '0;
        do_tick(1'b1);
        collect(spk, rdy, 256);
        @(negedge clk_i);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        chk("ovf_drop", 32'(drop_count_o), 32'd4);
        packet_ready_i = 1'b1;
        wait_done("ovf");
        exp_q = {};
        for (int i = 0; i < 16; i++) exp_q.push_back(9'h100 | 9'(i));
        chk_rx("ovf", exp_q);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Full FIFO with a simultaneous pop and push at index 16
        rx.delete(); done_cnt = 0;
        packet_ready_i = 1'b0;
        spk = '0;
        for (int i = 0; i < 17; i++) spk[i] = 1'b1;
        rdy = '0; rdy[16] = 1'b1;
        do_tick(1'b0);
        @(negedge clk_i);
        chk("tick_clr_ovf", 32'(overflow_o), 32'd0);
        chk("tick_clr_drop", 32'(drop_count_o), 32'd0);
        collect(spk, rdy, 256);
        @(negedge clk_i);
        chk("fullpop_ovf", 32'(overflow_o), 32'd0);
        chk("fullpop_drop", 32'(drop_count_o), 32'd0);
        packet_ready_i = 1'b1;
        wait_done("fullpop");
        exp_q = {};
        for (int i = 0; i < 17; i++) exp_q.push_back(9'(i));
        chk_rx("fullpop", exp_q);

        // Reset mid-COLLECT with three entries queued
        rx.delete(); done_cnt = 0;
        packet_ready_i = 1'b0;
        spk = '0; spk[1] = 1'b1; spk[2] = 1'b1; spk[3] = 1'b1;
        rdy = '0;
        do_tick(1'b1);
        collect(spk, rdy, 10);
        @(negedge clk_i);
        chk("mid_valid_pre", 32'(packet_valid_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(packet_valid_o), 32'd0);
        chk("mid_rst_pkt", 32'(packet_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_ovf", 32'(overflow_o), 32'd0);
        chk("mid_rst_drop", 32'(drop_count_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        packet_ready_i = 1'b1;
        spk = '0; rdy = '1;
        do_tick(1'b0);
        collect(spk, rdy, 256);
        wait_done("postrst");
        chk("postrst_pkts", 32'(rx.size()), 32'd0);

        // neuron_valid_i in IDLE and tick_i during DRAIN are ignored
        rx.delete(); done_cnt = 0;
        @(posedge clk_i); #1;
        neuron_valid_i = 1'b1; neuron_idx_i = 8'd255; spike_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        neuron_valid_i = 1'b0; spike_i = 1'b0;
        @(negedge clk_i);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_valid", 32'(packet_valid_o), 32'd0);
        packet_ready_i = 1'b0;
        spk = '0; spk[5] = 1'b1; rdy = '0;
        do_tick(1'b0);
        collect(spk, rdy, 256);
        @(posedge clk_i); #1;
        tick_i = 1'b1; core_id_i = 1'b1;
        neuron_valid_i = 1'b1; neuron_idx_i = 8'd7; spike_i = 1'b1;
        @(posedge clk_i); #1;
        tick_i = 1'b0; neuron_valid_i = 1'b0; spike_i = 1'b0;
        @(negedge clk_i);
        chk("drain_busy", 32'(busy_o), 32'd1);
        chk("drain_head", 32'(packet_o), 32'h005);
        packet_ready_i = 1'b1;
        wait_done("drain");
        exp_q = '{9'h005};
        chk_rx("drain", exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
